// File: rtl/c0_read_arbiter.sv
// rtl/c0_read_arbiter.sv - two-requester round-robin read arbiter for the c0 host read channel
// Grants are combinational; the c0Tx request is registered, so it issues one cycle after the grant.
module c0_read_arbiter #(
  parameter int ADDR_W  = 42,
  parameter int MAX_OUT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  output logic [1:0]        req_ack,
  input  logic              c0TxAlmFull,
  output logic              c0TxValid,
  output logic [ADDR_W-1:0] c0TxAddr,
  output logic [15:0]       c0TxMdata,
  input  logic              c0RxRdValid,
  input  logic [15:0]       c0RxMdata,
  output logic [1:0]        rsp_valid,
  output logic [7:0]        outstanding0,
  output logic [7:0]        outstanding1,
  output logic              idle
);

  localparam logic [7:0] MAX_C = 8'(MAX_OUT);

  logic            r_last_grant;
  logic [7:0]      r_cnt0;
  logic [7:0]      r_cnt1;
  logic            r_err;
  logic            r_tx_valid;
  logic [ADDR_W-1:0] r_tx_addr;
  logic [15:0]     r_tx_mdata;

  logic [1:0]      w_elig;
  logic [1:0]      w_gnt;
  logic [1:0]      w_dec;
  logic            w_unused_mdata;

  // Tag bits above the requester id are never produced by this block.
  assign w_unused_mdata = ^c0RxMdata[15:1];

  assign w_elig[0] = req_valid[0] & enable & ~c0TxAlmFull & (r_cnt0 < MAX_C);
  assign w_elig[1] = req_valid[1] & enable & ~c0TxAlmFull & (r_cnt1 < MAX_C);

  always_comb begin
    w_gnt = 2'b00;
    if (reset) begin
      if (&w_elig) begin
        w_gnt = r_last_grant ? 2'b01 : 2'b10;
      end else begin
        w_gnt = w_elig;
      end
    end
  end

  assign req_ack   = w_gnt;
  assign w_dec[0]  = c0RxRdValid & ~c0RxMdata[0];
  assign w_dec[1]  = c0RxRdValid &  c0RxMdata[0];
  assign rsp_valid = w_dec;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_grant <= 1'b1;
      r_tx_valid   <= 1'b0;
      r_tx_addr    <= '0;
      r_tx_mdata   <= '0;
    end else begin
      r_tx_valid <= |w_gnt;
      if (|w_gnt) begin
        r_last_grant <= w_gnt[1];
        r_tx_addr    <= w_gnt[1] ? req_addr1 : req_addr0;
        r_tx_mdata   <= {15'b0, w_gnt[1]};
      end
    end
  end

  // A response with nothing in flight saturates at zero and latches the error flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
      r_err  <= 1'b0;
    end else begin
      unique case ({w_gnt[0], w_dec[0]})
        2'b10:   r_cnt0 <= r_cnt0 + 8'd1;
        2'b01:   if (r_cnt0 == 8'd0) r_err <= 1'b1; else r_cnt0 <= r_cnt0 - 8'd1;
        default: r_cnt0 <= r_cnt0;
      endcase
      unique case ({w_gnt[1], w_dec[1]})
        2'b10:   r_cnt1 <= r_cnt1 + 8'd1;
        2'b01:   if (r_cnt1 == 8'd0) r_err <= 1'b1; else r_cnt1 <= r_cnt1 - 8'd1;
        default: r_cnt1 <= r_cnt1;
      endcase
    end
  end

  assign c0TxValid    = r_tx_valid;
  assign c0TxAddr     = r_tx_addr;
  assign c0TxMdata    = r_tx_mdata;
  assign outstanding0 = r_cnt0;
  assign outstanding1 = r_cnt1;
  assign idle         = (r_cnt0 == 8'd0) && (r_cnt1 == 8'd0) && !r_tx_valid && !r_err;

endmodule
